// File: rtl/transmitter_uart.sv
// Transmit-only UART: 8 data bits LSB first, optional even/odd parity, one stop bit,
// 16 x16-oversample ticks per bit. All outputs come straight from flip-flops.
`timescale 1ns/1ps
module transmitter_uart (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_Clock,
  input  logic       tx_start,
  input  logic [7:0] data_out_tx,
  input  logic       parity_mode,
  input  logic       parity_enable,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       mode_q, mode_d;
  logic       en_q, en_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       bit_end;
  logic       parity_bit;

  assign bit_end = i_Clock && (s_q == 4'd15);

  // Even mode makes the total count of ones even; odd mode makes it odd.
  assign parity_bit = mode_q ? (^data_q) : (~^data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= 4'd0;
      n_q     <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    data_d  = data_q;
    mode_d  = mode_q;
    en_d    = en_q;
    done_d  = 1'b0;

    // The 4-bit tick counter wraps 15 -> 0 exactly on the bit boundary.
    if (state_q != StIdle && i_Clock) begin
      s_d = s_q + 4'd1;
    end

    case (state_q)
      StIdle: begin
        if (tx_start) begin
          shift_d = data_out_tx;
          data_d  = data_out_tx;
          mode_d  = parity_mode;
          en_d    = parity_enable;
          s_d     = 4'd0;
          n_d     = 3'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (n_q == 3'd7) begin
            state_d = en_q ? StParity : StStop;
          end else begin
            n_d = n_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Line level is decoded from the next state so tx lands in a flop with the state.
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_bit;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != StIdle);
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_transmitter_uart.sv
// Bench for transmitter_uart: tick-count reference model checked every cycle, a loopback
// receiver decoding the line, and directed frames with hand-computed expectations.
`timescale 1ns/1ps
module tb_transmitter_uart;

  logic       clk;
  logic       rst_n;
  logic       i_Clock;
  logic       tx_start;
  logic [7:0] data_out_tx;
  logic       parity_mode;
  logic       parity_enable;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  int vectors     = 0;
  int miscompares = 0;
  int tick_mode   = 0;
  bit chk_on      = 0;

  transmitter_uart dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_Clock      (i_Clock),
    .tx_start     (tx_start),
    .data_out_tx  (data_out_tx),
    .parity_mode  (parity_mode),
    .parity_enable(parity_enable),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Whole frame as line levels, index 0 = start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic pm, input logic pe);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f = '0;
    f[8:1] = d;
    if (pe) begin
      f[9]  = pm ? logic'(ones % 2) : logic'((ones + 1) % 2);
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  // Reference model: a frame is a bit list; the line shows bit (ticks/16).
  logic        m_active;
  logic        m_done;
  logic [10:0] m_frame;
  logic [7:0]  m_byte;
  logic        m_pm;
  logic        m_pe;
  int          m_nbits;
  int          m_ticks;
  int          m_accepts = 0;
  logic        exp_tx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_ticks  <= 0;
      m_nbits  <= 10;
      m_frame  <= '1;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (tx_start) begin
          m_active  <= 1'b1;
          m_ticks   <= 0;
          m_frame   <= frame_of(data_out_tx, parity_mode, parity_enable);
          m_nbits   <= parity_enable ? 11 : 10;
          m_byte    <= data_out_tx;
          m_pm      <= parity_mode;
          m_pe      <= parity_enable;
          m_accepts <= m_accepts + 1;
        end
      end else if (i_Clock) begin
        m_ticks <= m_ticks + 1;
        if (m_ticks + 1 == 16 * m_nbits) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
      end
    end
  end

  assign exp_tx = m_active ? m_frame[m_ticks / 16] : 1'b1;

  always @(negedge clk) begin
    if (chk_on) check("tx_busy_done", {tx, tx_busy, tx_done_tick}, {exp_tx, m_active, m_done});
  end

  int done_total = 0;
  int done_cnt   = 0;
  int busy_ticks = 0;
  always @(negedge clk) if (tx_done_tick === 1'b1) begin done_total++; done_cnt++; end
  always @(posedge clk) if (i_Clock === 1'b1 && tx_busy === 1'b1) busy_ticks++;

  // Loopback receiver: start detected on a tick, each bit sampled at its 8th tick.
  logic        rx_on;
  logic        rx_pm;
  logic        rx_pe;
  logic [7:0]  rx_exp;
  logic [10:0] rx_raw;
  logic [10:0] rx_last = '0;
  int          rx_t;
  int          rx_n;
  int          rx_done = 0;
  int          rt;
  logic [10:0] rr;
  logic        par_want;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_on <= 1'b0;
      rx_t  <= 0;
    end else if (i_Clock) begin
      if (!rx_on) begin
        if (tx == 1'b0) begin
          rx_on  <= 1'b1;
          rx_t   <= 1;
          rx_raw <= '0;
          rx_n   <= m_nbits;
          rx_pm  <= m_pm;
          rx_pe  <= m_pe;
          rx_exp <= m_byte;
        end
      end else begin
        rt = rx_t + 1;
        rr = rx_raw;
        rx_t <= rt;
        if (rt % 16 == 8) begin
          rr[rt / 16] = tx;
          rx_raw <= rr;
          if (rt / 16 == rx_n - 1) begin
            rx_on   <= 1'b0;
            rx_last <= rr;
            rx_done++;
            check("rx_byte", rr[8:1], rx_exp);
            check("rx_framing", {rr[0], rr[rx_n - 1]}, 2'b01);
            if (rx_pe) begin
              par_want = !rx_pm;
              check("rx_parity", ^rr[9:1], par_want);
            end
          end
        end
      end
    end
  end

  initial begin
    int ph;
    ph = 0;
    i_Clock = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        0: begin
          ph = (ph + 1) % 4;
          i_Clock = (ph == 0);
        end
        1:       i_Clock = ($urandom_range(7) != 0);
        default: i_Clock = 1'b0;
      endcase
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", vectors);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic pm, input logic pe, input bit pester);
    int g;
    int low;
    int a0;
    data_out_tx   = d;
    parity_mode   = pm;
    parity_enable = pe;
    tx_start      = 1'b1;
    a0 = m_accepts;
    g  = 0;
    while (m_accepts == a0 && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    done_cnt   = 0;
    busy_ticks = 0;
    check("accepted", m_accepts - a0, 1);
    tx_start      = 1'b0;
    data_out_tx   = ~d;
    parity_mode   = !pm;
    parity_enable = !pe;
    low = 0;
    g   = 0;
    while (tx_done_tick !== 1'b1 && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
      tx_start = pester && (g < 400) && ($urandom_range(2) == 0);
      if (!tx_busy && !tx_done_tick) low++;
    end
    tx_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("busy_gaps", low, 0);
    check("done_count", done_cnt, 1);
    check("frame_ticks", busy_ticks, pe ? 176 : 160);
  endtask

  initial begin
    int g;
    int a0;
    int d0;
    int r0;
    rst_n         = 1'b0;
    tx_start      = 1'b0;
    data_out_tx   = 8'h00;
    parity_mode   = 1'b0;
    parity_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done_tick, 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_tx", tx, 1);

    send(8'h55, 1'b0, 1'b0, 1'b0);
    check("frame55_bits", rx_last, 11'b01010101010);
    send(8'hA3, 1'b1, 1'b1, 1'b0);
    check("frameA3_even", rx_last, 11'b10101000110);
    send(8'hA3, 1'b0, 1'b1, 1'b0);
    check("frameA3_odd", rx_last, 11'b11101000110);
    send(8'h0F, 1'b0, 1'b0, 1'b1);
    check("frame0F_bits", rx_last, 11'b01000011110);

    // Abort a frame in the middle of data bit 3.
    data_out_tx   = 8'hC6;
    parity_mode   = 1'b1;
    parity_enable = 1'b1;
    tx_start      = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    done_cnt = 0;
    r0 = rx_done;
    g  = 0;
    while (!(m_active && m_ticks == 16 * 4 + 5) && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("reach_data_bit3", (g < 2000), 1);
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_done", tx_done_tick, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_rx", rx_done - r0, 0);
    send(8'h81, 1'b0, 1'b0, 1'b0);
    check("frame81_bits", rx_last, 11'b01100000010);

    // Loopback: random bytes and parity, tx_start held high for back-to-back frames.
    tick_mode = 1;
    d0 = done_total;
    r0 = rx_done;
    data_out_tx   = 8'($urandom);
    parity_mode   = 1'($urandom_range(1));
    parity_enable = 1'($urandom_range(1));
    tx_start      = 1'b1;
    for (int f = 0; f < 256; f++) begin
      a0 = m_accepts;
      g  = 0;
      while (m_accepts == a0 && g < 2000) begin
        @(posedge clk);
        #1;
        g++;
      end
      if (m_accepts == a0) begin
        check("loop_accept", m_accepts - a0, 1);
        break;
      end
      if (f == 255) begin
        tx_start = 1'b0;
      end else begin
        data_out_tx   = 8'($urandom);
        parity_mode   = 1'($urandom_range(1));
        parity_enable = 1'($urandom_range(1));
      end
      if (f == 10) begin
        tick_mode = 2;
        repeat (40) @(posedge clk);
        #1;
        tick_mode = 1;
      end
    end
    tx_start = 1'b0;
    g = 0;
    while (done_total - d0 < 256 && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (20) @(posedge clk);
    #1;
    check("loop_tx_done", done_total - d0, 256);
    check("loop_rx_done", rx_done - r0, 256);
    check("loop_idle_tx", tx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
